// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C master driver and its timebase.
package i2c_pkg;

   typedef enum logic [3:0] {
      IDLE,
      START,
      ADDR,
      ADDR_ACK,
      WDATA,
      WDATA_ACK,
      RDATA,
      RDATA_ACK,
      STOP,
      DONE
   } i2c_m_state_t;

   typedef enum logic [1:0] {
      Q0 = 2'd0,
      Q1 = 2'd1,
      Q2 = 2'd2,
      Q3 = 2'd3
   } i2c_quarter_t;

   localparam logic I2C_RW_WRITE = 1'b0;
   localparam logic I2C_RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_master_tick.sv
// Bit-slot timebase: splits each SCL bit slot into four quarters of CLK_DIV clk
// cycles, flags the SDA sample point (last clk of Q2) and the slot end.
module i2c_master_tick
   import i2c_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         run,
   input  logic         hold,
   output i2c_quarter_t quarter,
   output logic         sample_stb,
   output logic         slot_end
);

   localparam int            CW       = $clog2(CLK_DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_reg;
   i2c_quarter_t  quarter_reg;
   logic          cnt_last;
   logic          stall;

   assign cnt_last = (cnt_reg == CNT_LAST);
   // A slave holding SCL low only stretches the released (high) phase.
   assign stall    = hold && (quarter_reg == Q2);

   // Quarter counter: parked at Q0/0 whenever no transfer is running.
   always_ff @(posedge clk) begin
      if (!rst_n || !run) begin
         cnt_reg     <= '0;
         quarter_reg <= Q0;
      end else if (!stall) begin
         if (cnt_last) begin
            cnt_reg     <= '0;
            quarter_reg <= i2c_quarter_t'(quarter_reg + 2'd1);
         end else begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end
   end

   assign quarter    = quarter_reg;
   assign sample_stb = (quarter_reg == Q2) && cnt_last && !stall;
   assign slot_end   = (quarter_reg == Q3) && cnt_last;

endmodule

// File: rtl/i2c_master_driver.sv
// Single-byte I2C master: START, address + R/W, ACK check, one data byte
// written or read, STOP. SCL/SDA are open-drain (driven 0 or released).
module i2c_master_driver
   import i2c_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_start,
   input  logic       i_rw,
   input  logic [6:0] i_chip_addr,
   input  logic [7:0] i_wdata,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_nack,
   output logic [7:0] o_rdata,
   output logic       o_rdata_valid,
   inout  wire        scl,
   inout  wire        sda
);

   i2c_m_state_t state_reg, state_next;
   logic [2:0]   bit_cnt_reg, bit_cnt_next;
   logic [7:0]   tx_shift_reg, tx_shift_next;
   logic [7:0]   rx_shift_reg, rx_shift_next;
   logic [7:0]   wdata_reg, wdata_next;
   logic [7:0]   rdata_reg, rdata_next;
   logic         rw_reg, rw_next;
   logic         sda_bit_reg, sda_bit_next;
   logic         nack_reg, nack_next;

   i2c_quarter_t quarter;
   logic         sample_stb;
   logic         slot_end;
   logic         running;
   logic         scl_in, sda_in;
   logic         scl_oe, sda_oe;

   assign scl_in  = scl;
   assign sda_in  = sda;
   assign running = (state_reg != IDLE) && (state_reg != DONE);

   i2c_master_tick #(
      .CLK_DIV    (CLK_DIV)
   ) u_tick (
      .clk        (clk),
      .rst_n      (rst_n),
      .run        (running),
      .hold       (!scl_in),
      .quarter    (quarter),
      .sample_stb (sample_stb),
      .slot_end   (slot_end)
   );

   // State and datapath registers; reset releases the bus at once (no STOP).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         bit_cnt_reg  <= 3'd0;
         tx_shift_reg <= 8'h00;
         rx_shift_reg <= 8'h00;
         wdata_reg    <= 8'h00;
         rdata_reg    <= 8'h00;
         rw_reg       <= I2C_RW_WRITE;
         sda_bit_reg  <= 1'b0;
         nack_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         bit_cnt_reg  <= bit_cnt_next;
         tx_shift_reg <= tx_shift_next;
         rx_shift_reg <= rx_shift_next;
         wdata_reg    <= wdata_next;
         rdata_reg    <= rdata_next;
         rw_reg       <= rw_next;
         sda_bit_reg  <= sda_bit_next;
         nack_reg     <= nack_next;
      end
   end

   // Next-state logic; every slot decision is taken at the slot end so SDA
   // only moves on entry to Q0 of the following slot.
   always_comb begin
      state_next    = state_reg;
      bit_cnt_next  = bit_cnt_reg;
      tx_shift_next = tx_shift_reg;
      rx_shift_next = rx_shift_reg;
      wdata_next    = wdata_reg;
      rdata_next    = rdata_reg;
      rw_next       = rw_reg;
      sda_bit_next  = sample_stb ? sda_in : sda_bit_reg;
      nack_next     = nack_reg;

      case (state_reg)
         IDLE: begin
            if (i_start) begin
               state_next    = START;
               rw_next       = i_rw;
               tx_shift_next = {i_chip_addr, i_rw};
               wdata_next    = i_wdata;
               nack_next     = 1'b0;
               bit_cnt_next  = 3'd7;
            end
         end
         START: begin
            if (slot_end) state_next = ADDR;
         end
         ADDR, WDATA: begin
            if (slot_end) begin
               tx_shift_next = {tx_shift_reg[6:0], 1'b0};
               if (bit_cnt_reg == 3'd0) begin
                  state_next = (state_reg == ADDR) ? ADDR_ACK : WDATA_ACK;
               end else begin
                  bit_cnt_next = bit_cnt_reg - 3'd1;
               end
            end
         end
         ADDR_ACK: begin
            if (slot_end) begin
               bit_cnt_next = 3'd7;
               if (sda_bit_reg) begin
                  nack_next  = 1'b1;
                  state_next = STOP;
               end else if (rw_reg == I2C_RW_READ) begin
                  state_next = RDATA;
               end else begin
                  state_next    = WDATA;
                  tx_shift_next = wdata_reg;
               end
            end
         end
         WDATA_ACK: begin
            if (slot_end) begin
               if (sda_bit_reg) nack_next = 1'b1;
               state_next = STOP;
            end
         end
         RDATA: begin
            if (sample_stb) rx_shift_next = {rx_shift_reg[6:0], sda_in};
            if (slot_end) begin
               if (bit_cnt_reg == 3'd0) begin
                  state_next = RDATA_ACK;
               end else begin
                  bit_cnt_next = bit_cnt_reg - 3'd1;
               end
            end
         end
         RDATA_ACK: begin
            if (slot_end) state_next = STOP;
         end
         STOP: begin
            if (slot_end) begin
               state_next = DONE;
               // Publish the read byte so it is valid in the DONE cycle.
               if ((rw_reg == I2C_RW_READ) && !nack_reg) rdata_next = rx_shift_reg;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Open-drain enables decoded from state and quarter.
   always_comb begin
      scl_oe = 1'b0;
      sda_oe = 1'b0;
      case (state_reg)
         START: begin
            sda_oe = (quarter == Q2) || (quarter == Q3);
            scl_oe = (quarter == Q3);
         end
         ADDR, WDATA: begin
            scl_oe = (quarter == Q0) || (quarter == Q1);
            sda_oe = !tx_shift_reg[7];
         end
         ADDR_ACK, WDATA_ACK, RDATA, RDATA_ACK: begin
            scl_oe = (quarter == Q0) || (quarter == Q1);
         end
         STOP: begin
            scl_oe = (quarter == Q0) || (quarter == Q1);
            sda_oe = (quarter != Q3);
         end
         default: begin
            scl_oe = 1'b0;
            sda_oe = 1'b0;
         end
      endcase
   end

   assign scl = scl_oe ? 1'b0 : 1'bz;
   assign sda = sda_oe ? 1'b0 : 1'bz;

   assign o_busy        = running;
   assign o_done        = (state_reg == DONE);
   assign o_nack        = nack_reg;
   assign o_rdata       = rdata_reg;
   assign o_rdata_valid = (state_reg == DONE) && (rw_reg == I2C_RW_READ) && !nack_reg;

endmodule
